// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window generator.
//   PW          : pixel width (8-bit R, G, B packed as R[23:16], G[15:8], B[7:0])
//   pixel_t     : one packed RGB pixel
//   KSIZE_3/5/7 : the kernel sizes the window generator supports
//   ksize_legal : true when a kernel size is one of the supported values
package conv_pkg;

   localparam int unsigned PW = 24;

   typedef logic [PW-1:0] pixel_t;

   localparam int unsigned KSIZE_3 = 3;
   localparam int unsigned KSIZE_5 = 5;
   localparam int unsigned KSIZE_7 = 7;

   function automatic bit ksize_legal(input int unsigned k);
      return (k == KSIZE_3) || (k == KSIZE_5) || (k == KSIZE_7);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image-row store: DEPTH entries of pixel_t.
//   clk   : rising-edge clock
//   we    : write enable (one write per accepted pixel)
//   addr  : column address, shared by the read and the write
//   wdata : pixel written at addr
//   rdata : pixel currently stored at addr (value before this cycle's write)
// Contents are deliberately not reset.
module line_buffer
   import conv_pkg::*;
#(
   parameter int unsigned DEPTH = 192,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pixel_t        wdata,
   output pixel_t        rdata
);

   pixel_t mem [DEPTH];

   // Read-before-write: the old row value leaves while the new one lands.
   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KSIZE x KSIZE window generator over a raster-order pixel stream.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : upstream pixel valid
//   in_ready   : a pixel is accepted this cycle when in_valid is also high
//   in_pixel   : raster-order pixel, top-left first
//   win_valid  : window output valid
//   win_ready  : downstream accepts the window
//   win_data   : flattened window, slot i*KSIZE+j holds pixel (r-KSIZE+1+i, c-KSIZE+1+j)
//   win_row    : image row of the window's bottom-right pixel
//   win_col    : image column of the window's bottom-right pixel
//   frame_done : high together with the last window of a frame
module conv_window_gen #(
   parameter int unsigned ROWS  = 192,
   parameter int unsigned COLS  = 192,
   parameter int unsigned KSIZE = 3,
   parameter int unsigned PW    = conv_pkg::PW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PW-1:0]             in_pixel,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [KSIZE*KSIZE*PW-1:0] win_data,
   output logic [15:0]               win_row,
   output logic [15:0]               win_col,
   output logic                      frame_done
);

   import conv_pkg::*;

   localparam int unsigned AW  = $clog2(COLS);
   localparam int unsigned NLB = KSIZE - 1;

   if (!ksize_legal(KSIZE) || (KSIZE > ROWS) || (KSIZE > COLS) || (PW != $bits(pixel_t)))
   begin : g_bad_params
      $error("conv_window_gen: KSIZE must be 3, 5 or 7 and fit the image; PW must match pixel_t");
   end

   logic [15:0] row_q, row_d, col_q, col_d;
   logic        win_valid_q, win_valid_d;
   logic [15:0] win_row_q, win_row_d, win_col_q, win_col_d;
   logic        frame_done_q, frame_done_d;
   logic        accept, qualify, last_col, last_row;

   pixel_t lb_rd   [NLB];
   pixel_t col_pix [KSIZE];    // col_pix[k] = pixel (row_q - k, col_q)
   pixel_t win_q   [KSIZE][KSIZE];

   assign in_ready = !win_valid_q || win_ready;
   assign accept   = in_valid && in_ready;
   assign last_col = (col_q == 16'(COLS - 1));
   assign last_row = (row_q == 16'(ROWS - 1));
   // Counters alone decide validity, so line-buffer leftovers never escape.
   assign qualify  = accept && (row_q >= 16'(KSIZE - 1)) && (col_q >= 16'(KSIZE - 1));

   // Line buffers form a chain: buffer k holds row r-1-k at each column.
   always_comb begin
      col_pix[0] = in_pixel;
      for (int k = 0; k < int'(NLB); k++) begin
         col_pix[k+1] = lb_rd[k];
      end
   end

   for (genvar k = 0; k < NLB; k++) begin : g_lb
      line_buffer #(
         .DEPTH (COLS),
         .AW    (AW)
      ) u_line_buffer (
         .clk   (clk),
         .we    (accept),
         .addr  (col_q[AW-1:0]),
         .wdata (col_pix[k]),
         .rdata (lb_rd[k])
      );
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_valid_d  = win_valid_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      frame_done_d = frame_done_q;
      if (accept) begin
         col_d        = last_col ? 16'd0 : col_q + 16'd1;
         if (last_col) begin
            row_d = last_row ? 16'd0 : row_q + 16'd1;
         end
         win_valid_d  = qualify;
         win_row_d    = row_q;
         win_col_d    = col_q;
         frame_done_d = qualify && last_row && last_col;
      end else if (win_ready) begin
         win_valid_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q        <= '0;
         col_q        <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Window shifts left one column per accepted pixel; the new column enters at the right.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(KSIZE); i++) begin
            for (int j = 0; j < int'(KSIZE); j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else if (accept) begin
         for (int i = 0; i < int'(KSIZE); i++) begin
            for (int j = 0; j < int'(KSIZE) - 1; j++) begin
               win_q[i][j] <= win_q[i][j+1];
            end
            win_q[i][KSIZE-1] <= col_pix[KSIZE-1-i];
         end
      end
   end

   for (genvar i = 0; i < KSIZE; i++) begin : g_row
      for (genvar j = 0; j < KSIZE; j++) begin : g_col
         assign win_data[(i*KSIZE+j)*PW +: PW] = win_q[i][j];
      end
   end

   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on 8x8 images with KSIZE 3 and 7.
module tb_conv_window_gen;

   localparam int N  = 8;
   localparam int W3 = 9 * 24;
   localparam int W7 = 49 * 24;

   typedef struct {
      logic [15:0]   row;
      logic [15:0]   col;
      logic          fd;
      logic [W7-1:0] data;
   } win_t;

   typedef struct {
      int          k;
      int          n;
      int          exp_row;
      int          exp_col;
      int          slot;
      logic [23:0] exp_px;
      logic        exp_fd;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid3, in_ready3, win_valid3, win_ready3, frame_done3;
   logic [23:0]   in_pixel3;
   logic [W3-1:0] win_data3;
   logic [15:0]   win_row3, win_col3;
   logic          in_valid7, in_ready7, win_valid7, win_ready7, frame_done7;
   logic [23:0]   in_pixel7;
   logic [W7-1:0] win_data7;
   logic [15:0]   win_row7, win_col7;

   int   n_cmp = 0;
   int   n_bad = 0;
   win_t q3[$];
   win_t q7[$];
   win_t mon3, mon7;

   always #5 clk = ~clk;

   conv_window_gen #(.ROWS(N), .COLS(N), .KSIZE(3), .PW(24)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_pixel(in_pixel3),
      .win_valid(win_valid3), .win_ready(win_ready3), .win_data(win_data3),
      .win_row(win_row3), .win_col(win_col3), .frame_done(frame_done3)
   );

   conv_window_gen #(.ROWS(N), .COLS(N), .KSIZE(7), .PW(24)) u_dut7 (
      .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7), .in_pixel(in_pixel7),
      .win_valid(win_valid7), .win_ready(win_ready7), .win_data(win_data7),
      .win_row(win_row7), .win_col(win_col7), .frame_done(frame_done7)
   );

   // Record each window as it is handed over at the coming rising edge.
   always @(negedge clk) begin
      if (!rst && win_valid3 && win_ready3) begin
         mon3.row = win_row3; mon3.col = win_col3; mon3.fd = frame_done3;
         mon3.data = '0; mon3.data[W3-1:0] = win_data3;
         q3.push_back(mon3);
      end
      if (!rst && win_valid7 && win_ready7) begin
         mon7.row = win_row7; mon7.col = win_col7; mon7.fd = frame_done7;
         mon7.data = win_data7;
         q7.push_back(mon7);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic win_t get_win(input int k, input int idx);
      win_t w;
      if (k == 3) w = q3[idx];
      else        w = q7[idx];
      return w;
   endfunction

   function automatic int qsize(input int k);
      return (k == 3) ? q3.size() : q7.size();
   endfunction

   // Every window of one frame against the ramp base + r*N + c.
   task automatic check_frame(input int k, input int qstart, input int base, input string name);
      int            nw = N - k + 1;
      int            total = nw * nw;
      int            er, ec, bad_slot;
      logic          efd;
      logic [W7-1:0] exp;
      win_t          w;
      if (qsize(k) < qstart + total) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_avail: got %0d windows, want %0d", name, qsize(k) - qstart, total);
         return;
      end
      for (int n = 0; n < total; n++) begin
         er  = k - 1 + n / nw;
         ec  = k - 1 + n % nw;
         efd = (er == N - 1) && (ec == N - 1);
         exp = '0;
         for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
               exp[(i*k+j)*24 +: 24] = 24'(base + (er - k + 1 + i) * N + (ec - k + 1 + j));
         w = get_win(k, qstart + n);
         n_cmp++;
         if (w.row != 16'(er) || w.col != 16'(ec) || w.fd != efd || w.data !== exp) begin
            n_bad++;
            bad_slot = 0;
            for (int s = k * k - 1; s >= 0; s--)
               if (w.data[s*24 +: 24] !== exp[s*24 +: 24]) bad_slot = s;
            $display("FAIL %s_win%0d: got (%0d,%0d) fd=%0b slot%0d=0x%06h, want (%0d,%0d) fd=%0b slot%0d=0x%06h",
                     name, n, w.row, w.col, w.fd, bad_slot, w.data[bad_slot*24 +: 24],
                     er, ec, efd, bad_slot, exp[bad_slot*24 +: 24]);
         end
      end
   endtask

   task automatic send_pixel(input int k, input logic [23:0] px, input bit gaps);
      int n = 0;
      if (gaps && $urandom_range(0, 1) == 1) begin
         if (k == 3) in_valid3 = 1'b0; else in_valid7 = 1'b0;
         @(negedge clk);
      end
      if (k == 3) begin in_valid3 = 1'b1; in_pixel3 = px; end
      else        begin in_valid7 = 1'b1; in_pixel7 = px; end
      while (((k == 3) ? !in_ready3 : !in_ready7) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
      end
      @(negedge clk);
      if (k == 3) in_valid3 = 1'b0; else in_valid7 = 1'b0;
   endtask

   task automatic send_frame(input int k, input int base, input bit gaps);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            send_pixel(k, 24'(base + r * N + c), gaps);
   endtask

   vec_t          vecs[10];
   int            qs, fd_cnt, wait_n;
   time           t0;
   win_t          w;
   logic [W3-1:0] sd;
   logic [32:0]   spos;

   initial begin
      rst = 1'b1;
      in_valid3 = 1'b0; in_pixel3 = '0; win_ready3 = 1'b1;
      in_valid7 = 1'b0; in_pixel7 = '0; win_ready7 = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_win_valid3", 64'(win_valid3), 64'd0);
      check("rst_win_pos3", 64'({win_row3, win_col3}), 64'd0);
      check("rst_frame_done3", 64'(frame_done3), 64'd0);
      check("rst_win_data3_nonzero", 64'(win_data3 != '0), 64'd0);
      check("rst_in_ready3", 64'(in_ready3), 64'd1);
      check("rst_win_valid7", 64'(win_valid7), 64'd0);
      check("rst_win_data7_nonzero", 64'(win_data7 != '0), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Gap-free ramp frames, K=3 then K=7.
      qs = q3.size();
      send_frame(3, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("k3_count", 64'(q3.size() - qs), 64'd36);
      check_frame(3, qs, 0, "k3_ramp");
      qs = q7.size();
      send_frame(7, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("k7_count", 64'(q7.size() - qs), 64'd4);
      check_frame(7, qs, 0, "k7_ramp");

      vecs = '{
         '{3,  0, 2, 2,  0, 24'h000000, 1'b0},
         '{3,  0, 2, 2,  4, 24'h000009, 1'b0},
         '{3,  0, 2, 2,  8, 24'h000012, 1'b0},
         '{3,  1, 2, 3,  8, 24'h000013, 1'b0},
         '{3, 35, 7, 7,  0, 24'h00002D, 1'b1},
         '{3, 35, 7, 7,  8, 24'h00003F, 1'b1},
         '{7,  0, 6, 6,  0, 24'h000000, 1'b0},
         '{7,  1, 6, 7, 48, 24'h000037, 1'b0},
         '{7,  3, 7, 7,  0, 24'h000009, 1'b1},
         '{7,  3, 7, 7, 48, 24'h00003F, 1'b1}
      };
      for (int v = 0; v < 10; v++) begin
         w = get_win(vecs[v].k, vecs[v].n);
         check($sformatf("vec%0d_pos", v), 64'({w.row, w.col}),
               64'({16'(vecs[v].exp_row), 16'(vecs[v].exp_col)}));
         check($sformatf("vec%0d_px", v), 64'(w.data[vecs[v].slot*24 +: 24]), 64'(vecs[v].exp_px));
         check($sformatf("vec%0d_fd", v), 64'(w.fd), 64'(vecs[v].exp_fd));
      end

      // Downstream stall of 5 cycles in the middle of a frame.
      qs = q3.size();
      fork
         send_frame(3, 0, 1'b0);
         begin
            wait_n = 0;
            do begin
               @(posedge clk); #1;
               wait_n++;
            end while (!(win_valid3 && q3.size() >= qs + 4) && wait_n < 200);
            if (wait_n >= 200) begin
               n_cmp++; n_bad++;
               $display("FAIL stall_setup: got no 5th window, want one within 200 cycles");
            end
            win_ready3 = 1'b0;
            sd   = win_data3;
            spos = {win_row3, win_col3, frame_done3};
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", 64'(in_ready3), 64'd0);
               check("stall_win_valid", 64'(win_valid3), 64'd1);
               check("stall_data_changed", 64'(win_data3 != sd), 64'd0);
               check("stall_pos_hold", 64'({win_row3, win_col3, frame_done3}), 64'(spos));
            end
            @(posedge clk); #1;
            win_ready3 = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      check("stall_count", 64'(q3.size() - qs), 64'd36);
      check_frame(3, qs, 0, "k3_stall");

      // Random input bubbles must not change the window stream.
      qs = q3.size();
      send_frame(3, 0, 1'b1);
      repeat (3) @(negedge clk);
      check("gaps_count", 64'(q3.size() - qs), 64'd36);
      check_frame(3, qs, 0, "k3_gaps");

      // Reset after 20 pixels of a frame, then a full new frame.
      for (int p = 0; p < 20; p++) send_pixel(3, 24'(32'h800000 + p), 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_win_valid", 64'(win_valid3), 64'd0);
      check("midrst_win_data_nonzero", 64'(win_data3 != '0), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      qs = q3.size();
      send_frame(3, 256, 1'b0);
      repeat (3) @(negedge clk);
      check("midrst_count", 64'(q3.size() - qs), 64'd36);
      check_frame(3, qs, 256, "k3_midrst");

      // Two frames back to back with no idle cycle between them.
      qs = q3.size();
      t0 = $time;
      send_frame(3, 0, 1'b0);
      send_frame(3, 64, 1'b0);
      check("b2b_cycles", 64'(($time - t0) / 10), 64'd128);
      repeat (3) @(negedge clk);
      check("b2b_count", 64'(q3.size() - qs), 64'd72);
      check_frame(3, qs, 0, "b2b_f1");
      check_frame(3, qs + 36, 64, "b2b_f2");
      fd_cnt = 0;
      for (int n = qs; n < q3.size(); n++) if (q3[n].fd) fd_cnt++;
      check("b2b_frame_done", 64'(fd_cnt), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
